// File: rtl/keccak_theta_stage.sv
// Keccak-f theta step with a registered two-entry skid buffer output.
// Lanes use byte-wise bit-reversed storage of the Keccak z index.
module keccak_theta_stage #(
    parameter int W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0][4:0][W-1:0]     in_state,
    input  logic [4:0]                 in_round,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0][4:0][W-1:0]     out_state,
    output logic [4:0]                 out_round
);

    typedef logic [4:0][4:0][W-1:0] state_t;
    typedef logic [W-1:0]           lane_t;

    // Physical bit position of Keccak index z.
    function automatic int phys(input int z);
        return 8 * (z / 8) + 7 - (z % 8);
    endfunction

    // Rotate by one Keccak position: bit z moves to z+1 mod W.
    function automatic lane_t rot1(input lane_t l);
        lane_t r;
        r = '0;
        for (int z = 0; z < W; z++) begin
            r[phys((z + 1) % W)] = l[phys(z)];
        end
        return r;
    endfunction

    logic [4:0][W-1:0] c_lane;
    logic [4:0][W-1:0] d_lane;
    state_t            theta_state;

    logic       main_valid_q, main_valid_d;
    state_t     main_state_q, main_state_d;
    logic [4:0] main_round_q, main_round_d;
    logic       skid_valid_q, skid_valid_d;
    state_t     skid_state_q, skid_state_d;
    logic [4:0] skid_round_q, skid_round_d;

    logic accept;
    logic deliver;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_state = main_state_q;
    assign out_round = main_round_q;

    assign accept  = in_valid & ~skid_valid_q;
    assign deliver = main_valid_q & out_ready;

    // Column parities, theta effect and the mixed state.
    always_comb begin
        c_lane      = '0;
        d_lane      = '0;
        theta_state = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                c_lane[x] = c_lane[x] ^ in_state[x][y];
            end
        end
        for (int x = 0; x < 5; x++) begin
            d_lane[x] = c_lane[(x + 4) % 5] ^ rot1(c_lane[(x + 1) % 5]);
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                theta_state[x][y] = in_state[x][y] ^ d_lane[x];
            end
        end
    end

    // Skid buffer next state: main feeds the output, skid absorbs one stall.
    always_comb begin
        main_valid_d = main_valid_q;
        main_state_d = main_state_q;
        main_round_d = main_round_q;
        skid_valid_d = skid_valid_q;
        skid_state_d = skid_state_q;
        skid_round_d = skid_round_q;
        if (!main_valid_q || (deliver && !skid_valid_q)) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_state_d = theta_state;
                main_round_d = in_round;
            end else if (deliver) begin
                main_valid_d = 1'b0;
            end
        end else if (!deliver) begin
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_state_d = theta_state;
                skid_round_d = in_round;
            end
        end else begin
            main_valid_d = 1'b1;
            main_state_d = skid_state_q;
            main_round_d = skid_round_q;
            skid_valid_d = 1'b0;
        end
    end

    // Entry registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_state_q <= '0;
            main_round_q <= '0;
            skid_valid_q <= 1'b0;
            skid_state_q <= '0;
            skid_round_q <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_state_q <= main_state_d;
            main_round_q <= main_round_d;
            skid_valid_q <= skid_valid_d;
            skid_state_q <= skid_state_d;
            skid_round_q <= skid_round_d;
        end
    end

endmodule

// File: tb/tb_keccak_theta_stage.sv
// Directed bench for keccak_theta_stage with a reference theta model.
// Checks are immediate assertions; failures are counted and summarised.
module tb_keccak_theta_stage;

    typedef logic [4:0][4:0][63:0] state_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    state_t     in_state;
    logic [4:0] in_round;
    logic       out_valid;
    logic       out_ready;
    state_t     out_state;
    logic [4:0] out_round;

    int checks = 0;
    int errors = 0;

    keccak_theta_stage #(.W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_round (out_round)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] brev8(input logic [63:0] l);
        logic [63:0] r;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 8; i++)
                r[8*b+i] = l[8*b+7-i];
        return r;
    endfunction

    function automatic logic [63:0] rotk(input logic [63:0] l);
        logic [63:0] t;
        t = brev8(l);
        t = {t[62:0], t[63]};
        return brev8(t);
    endfunction

    function automatic state_t theta_ref(input state_t a);
        logic [63:0] c [5];
        logic [63:0] d [5];
        state_t r;
        for (int x = 0; x < 5; x++)
            c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
        for (int x = 0; x < 5; x++)
            d[x] = c[(x+4)%5] ^ rotk(c[(x+1)%5]);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = a[x][y] ^ d[x];
        return r;
    endfunction

    function automatic state_t gen(input int k);
        state_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = (64'h9E37_79B9_7F4A_7C15 * 64'(x*5+y+1))
                          ^ (64'hC2B2_AE3D_27D4_EB4F * 64'(k+3));
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t obs,
                             input state_t exp);
        int fx;
        int fy;
        fx = 0;
        fy = 0;
        for (int x = 4; x >= 0; x--)
            for (int y = 4; y >= 0; y--)
                if (obs[x][y] !== exp[x][y]) begin
                    fx = x;
                    fy = y;
                end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: lane[%0d][%0d] observed %h expected %h",
                   tag, fx, fy, obs[fx][fy], exp[fx][fy]);
        end
    endtask

    state_t exp_s;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_round  = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_round", 64'(out_round), 64'd0);
        chk_state("reset out_state", out_state, '0);
        rst = 1'b0;
        step();

        // Single bit at Keccak z=0 of lane [0][0].
        out_ready = 1'b1;
        in_state  = '0;
        in_state[0][0] = 64'h80;
        in_round  = 5'd3;
        in_valid  = 1'b1;
        chk("single pre out_valid", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        exp_s = '0;
        exp_s[0][0] = 64'h80;
        for (int y = 0; y < 5; y++) begin
            exp_s[1][y] = 64'h80;
            exp_s[4][y] = 64'h40;
        end
        chk("single out_valid", 64'(out_valid), 64'd1);
        chk("single out_round", 64'(out_round), 64'd3);
        chk_state("single out_state", out_state, exp_s);
        step();
        chk("single drained", 64'(out_valid), 64'd0);

        // Rotation wrap from z=63 to z=0.
        in_state = '0;
        in_state[0][0] = 64'h0100_0000_0000_0000;
        in_round = 5'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp_s = '0;
        exp_s[0][0] = 64'h0100_0000_0000_0000;
        for (int y = 0; y < 5; y++) begin
            exp_s[1][y] = 64'h0100_0000_0000_0000;
            exp_s[4][y] = 64'h80;
        end
        chk_state("wrap out_state", out_state, exp_s);
        chk("wrap out_round", 64'(out_round), 64'd9);

        // All ones and all zeros pass through unchanged.
        in_state = '1;
        in_round = 5'd31;
        in_valid = 1'b1;
        step();
        chk_state("ones out_state", out_state, '1);
        in_state = '0;
        in_round = 5'd0;
        step();
        in_valid = 1'b0;
        chk_state("zeros out_state", out_state, '0);
        step();

        // Backpressure: two park, third is refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = gen(0);
        in_round  = 5'd0;
        chk("bp in_ready 0", 64'(in_ready), 64'd1);
        step();
        in_state = gen(1);
        in_round = 5'd1;
        chk("bp in_ready 1", 64'(in_ready), 64'd1);
        step();
        in_state = gen(2);
        in_round = 5'd2;
        chk("bp in_ready 2", 64'(in_ready), 64'd0);
        step();
        chk("bp stall in_ready", 64'(in_ready), 64'd0);
        chk("bp stall round", 64'(out_round), 64'd0);
        chk_state("bp stall state", out_state, theta_ref(gen(0)));
        out_ready = 1'b1;
        step();
        chk("bp out1 valid", 64'(out_valid), 64'd1);
        chk("bp out1 round", 64'(out_round), 64'd1);
        chk_state("bp out1 state", out_state, theta_ref(gen(1)));
        chk("bp reopen in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp out2 valid", 64'(out_valid), 64'd1);
        chk("bp out2 round", 64'(out_round), 64'd2);
        chk_state("bp out2 state", out_state, theta_ref(gen(2)));
        step();
        chk("bp drained", 64'(out_valid), 64'd0);

        // Full-rate stream of 24 items.
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_state = gen(i + 10);
            in_round = 5'(i);
            chk("stream in_ready", 64'(in_ready), 64'd1);
            step();
            chk("stream valid", 64'(out_valid), 64'd1);
            chk("stream round", 64'(out_round), 64'(i));
            chk_state("stream state", out_state, theta_ref(gen(i + 10)));
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", 64'(out_valid), 64'd0);

        // Reset with both entries full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = gen(40);
        in_round  = 5'd5;
        step();
        in_round = 5'd6;
        step();
        in_valid = 1'b0;
        chk("full in_ready", 64'(in_ready), 64'd0);
        chk("full out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst in_ready", 64'(in_ready), 64'd1);
        chk("arst out_round", 64'(out_round), 64'd0);
        chk_state("arst out_state", out_state, '0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post rst no stale", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b1;
        in_state = gen(50);
        in_round = 5'd7;
        step();
        in_valid = 1'b0;
        chk("post rst round", 64'(out_round), 64'd7);
        chk_state("post rst state", out_state, theta_ref(gen(50)));
        step();
        chk("post rst drained", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
